serv_rf_ram_ctrl: RTL and testbench
===================================

SERV_RF_RAM_CTRL -- requirements
Module: serv_rf_ram_ctrl

Interface
REQ-001 SHALL have parameter WITH_CSR, default 1: 1 adds 4 CSR registers (regs 32..35) and makes register addresses 6 bits wide; 0 makes them 5 bits wide.
REQ-002 SHALL derive localparam AW = 5+WITH_CSR+4 (RAM word address width); RAM word width is fixed at 2 bits.
REQ-003 i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  reset; synchronous, active-high.
REQ-005 i_rreq  input  1  one-cycle pulse: start a 32-bit read of i_rreg0/i_rreg1.
REQ-006 i_wreq  input  1  one-cycle pulse: start a 32-bit serial write.
REQ-007 o_ready  output  1  one-cycle pulse: the requested operation(s) are ready to stream.
REQ-008 i_rreg0, i_rreg1  input  5+WITH_CSR each  read register addresses, sampled at i_rreq.
REQ-009 i_wreg0, i_wreg1  input  5+WITH_CSR each  write register addresses, sampled at i_wreq.
REQ-010 i_wen0, i_wen1, i_wdata0, i_wdata1  input  1 each  serial write enables and write data, LSB first.
REQ-011 o_rdata0, o_rdata1  output  1 each  serial read data, LSB first.
REQ-012 o_waddr  output  AW; o_wdata  output  2; o_wen  output  1  RAM write port.
REQ-013 o_raddr  output  AW; i_rdata  input  2  RAM read port; i_rdata is valid one cycle after o_raddr.

Function
REQ-014 SHALL form every RAM address as {register, word index k}, with k in 0..15 and word k holding bits 2k+1:2k.
REQ-015 SHALL have states IDLE, ARM1, ARM2, RUN; IDLE->ARM1 on i_rreq|i_wreq; ARM1->ARM2; ARM2->RUN with o_ready=1 for that cycle; RUN lasts exactly 32 cycles (5-bit counter, cnt=0..31), then IDLE.
REQ-016 o_ready SHALL rise exactly 3 cycles after the request cycle t0 (in cycle t0+3); bit n streams in cycle t0+4+n.
REQ-017 i_rreq and i_wreq SHALL be ignored outside IDLE; if both are asserted in the same cycle, both operations SHALL run concurrently in one RUN phase.
REQ-018 Read: SHALL issue o_raddr alternately for rreg0 and rreg1, word by word, starting in ARM1, so that o_rdata0/o_rdata1 carry bit n of each operand in cycle t0+4+n with no gaps.
REQ-019 Read: SHALL drive a 0 operand on o_rdata0/o_rdata1 for register 0 regardless of i_rdata; SHALL drive 0 on both outside the read RUN phase.
REQ-020 Write: SHALL shift i_wdata0/i_wdata1 into 2-bit buffers during RUN and sample i_wen0/i_wen1 at odd bit 2k+1.
REQ-021 Write: port 0 word k SHALL go to RAM in the cycle after bit 2k+1 (o_wen=1, o_waddr={wreg0,k}); port 1 word k SHALL go to RAM one cycle later, with o_waddr={wreg1,k}.
REQ-022 Write: a word SHALL be skipped (o_wen=0) if its port's enable at bit 2k+1 is 0, or if port 0 targets register 0.
REQ-023 The last port 1 write (k=15) SHALL complete 2 cycles after RUN ends; a new request SHALL be accepted in IDLE while this drain is still pending.
REQ-024 SHALL perform at most one RAM write per cycle; port 0 and port 1 writes SHALL never collide.

Reset
REQ-025 With i_rst=1 at a clock edge: state IDLE, counter 0, o_ready=0, o_wen=0, o_rdata0=o_rdata1=0.
REQ-026 Reset mid-operation SHALL abort it: no RAM write after the reset edge and no o_ready pulse.
REQ-027 o_waddr, o_wdata and o_raddr need no reset value.

Verification
REQ-028 Read: RAM preloaded x5=0xDEADBEEF, x6=0x12345678; i_rreq with rreg0=5, rreg1=6 at t0 -> o_ready at t0+3; o_rdata0/o_rdata1 serialize 0xDEADBEEF/0x12345678 over t0+4..t0+35.
REQ-029 Read of x0 with RAM word {0,*}=2'b11 -> o_rdata0 all zeros for 32 cycles.
REQ-030 Write: i_wreq with wreg0=7, wen0=1 streaming 0xA5A5A5A5 -> 16 writes to {7,0..15} with correct pairs; wreg0=0 -> no o_wen.
REQ-031 Concurrent: i_rreq and i_wreq in the same cycle, wreg1=32 (CSR) with wen1=1 -> single o_ready; read data correct; port 0 and port 1 writes interleaved, never in the same cycle.
REQ-032 Busy and reset: i_rreq at cnt=10 -> ignored. i_rst at cnt=10 -> o_wen=0 from the next cycle, IDLE, no o_ready.

Source files
------------

// File: rtl/serv_rf_ram_ctrl.sv
// Bit-serial register file controller: maps 2-bit-wide RAM words onto 32-bit
// registers streamed LSB first, with two read ports and two write ports.
module serv_rf_ram_ctrl #(
  parameter int unsigned WITH_CSR = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rreq,
  input  logic                  i_wreq,
  output logic                  o_ready,
  input  logic [4+WITH_CSR:0]   i_rreg0,
  input  logic [4+WITH_CSR:0]   i_rreg1,
  input  logic [4+WITH_CSR:0]   i_wreg0,
  input  logic [4+WITH_CSR:0]   i_wreg1,
  input  logic                  i_wen0,
  input  logic                  i_wen1,
  input  logic                  i_wdata0,
  input  logic                  i_wdata1,
  output logic                  o_rdata0,
  output logic                  o_rdata1,
  output logic [8+WITH_CSR:0]   o_waddr,
  output logic [1:0]            o_wdata,
  output logic                  o_wen,
  output logic [8+WITH_CSR:0]   o_raddr,
  input  logic [1:0]            i_rdata
);

  localparam int unsigned RW = 5 + WITH_CSR;
  localparam int unsigned AW = 5 + WITH_CSR + 4;

  typedef enum logic [1:0] {IDLE, ARM1, ARM2, RUN} state_t;

  state_t        state, state_nxt;
  logic [4:0]    cnt;
  logic          rd_q, wr_q;
  logic [RW-1:0] rreg0_q, rreg1_q, wreg0_q, wreg1_q;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_rreq || i_wreq) state_nxt = ARM1;
      ARM1:    state_nxt = ARM2;
      ARM2:    state_nxt = RUN;
      RUN:     if (cnt == 5'd31) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      o_ready <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_ready <= (state == ARM2);
      cnt     <= (state == RUN) ? cnt + 5'd1 : '0;
      if (state == IDLE && (i_rreq || i_wreq)) begin
        rd_q    <= i_rreq;
        wr_q    <= i_wreq;
        rreg0_q <= i_rreg0;
        rreg1_q <= i_rreg1;
        wreg0_q <= i_wreg0;
        wreg1_q <= i_wreg1;
      end
    end
  end

  // Read addresses alternate rreg0/rreg1 one word ahead of the output stream.
  logic       rsel;
  logic [3:0] rword;

  always_comb begin
    rsel  = 1'b0;
    rword = '0;
    unique case (state)
      ARM1:    rsel = 1'b0;
      ARM2:    rsel = 1'b1;
      RUN: begin
        rsel  = cnt[0];
        rword = cnt[4:1] + 4'd1;
      end
      default: rsel = 1'b0;
    endcase
    o_raddr = {rsel ? rreg1_q : rreg0_q, rword};
  end

  logic [1:0] rbuf0, rbuf1;
  logic       rgate0, rgate1;

  assign rgate0 = rd_q && (rreg0_q != '0);
  assign rgate1 = rd_q && (rreg1_q != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rdata0 <= 1'b0;
      o_rdata1 <= 1'b0;
    end else begin
      o_rdata0 <= 1'b0;
      o_rdata1 <= 1'b0;
      if (state == ARM2 || (state == RUN && cnt[0])) rbuf0 <= i_rdata;
      if (state == RUN) begin
        if (!cnt[0]) begin
          rbuf1    <= i_rdata;
          o_rdata0 <= rbuf0[0] & rgate0;
          o_rdata1 <= i_rdata[0] & rgate1;
        end else begin
          o_rdata0 <= rbuf0[1] & rgate0;
          o_rdata1 <= rbuf1[1] & rgate1;
        end
      end
    end
  end

  // Write stream lags the counter by one cycle; port 1 words are staged with
  // their own address so a new request can reload wreg1_q during the drain.
  logic          w_act;
  logic [4:0]    w_cnt;
  logic          wb0, wb1;
  logic          p1_pend, p1_en;
  logic [AW-1:0] p1_addr;
  logic [1:0]    p1_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      w_act   <= 1'b0;
      w_cnt   <= '0;
      p1_pend <= 1'b0;
      o_wen   <= 1'b0;
    end else begin
      w_act <= (state == RUN) && wr_q;
      w_cnt <= cnt;
      if (w_act && !w_cnt[0]) begin
        wb0 <= i_wdata0;
        wb1 <= i_wdata1;
      end
      if (w_act && w_cnt[0]) begin
        o_wen   <= i_wen0 && (wreg0_q != '0);
        o_waddr <= {wreg0_q, w_cnt[4:1]};
        o_wdata <= {i_wdata0, wb0};
        p1_pend <= 1'b1;
        p1_en   <= i_wen1;
        p1_addr <= {wreg1_q, w_cnt[4:1]};
        p1_data <= {i_wdata1, wb1};
      end else if (p1_pend) begin
        o_wen   <= p1_en;
        o_waddr <= p1_addr;
        o_wdata <= p1_data;
        p1_pend <= 1'b0;
      end else begin
        o_wen <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serv_rf_ram_ctrl.sv
// Directed bench for serv_rf_ram_ctrl with a behavioural 2-bit RAM.
module tb_serv_rf_ram_ctrl;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1, i_rreq = 1'b0, i_wreq = 1'b0;
  logic       o_ready;
  logic [5:0] i_rreg0 = '0, i_rreg1 = '0, i_wreg0 = '0, i_wreg1 = '0;
  logic       i_wen0 = 1'b0, i_wen1 = 1'b0, i_wdata0 = 1'b0, i_wdata1 = 1'b0;
  logic       o_rdata0, o_rdata1;
  logic [9:0] o_waddr, o_raddr;
  logic [1:0] o_wdata, i_rdata;
  logic       o_wen;

  always #5 clk = ~clk;

  serv_rf_ram_ctrl #(.WITH_CSR(1)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_rreq(i_rreq), .i_wreq(i_wreq),
    .o_ready(o_ready), .i_rreg0(i_rreg0), .i_rreg1(i_rreg1),
    .i_wreg0(i_wreg0), .i_wreg1(i_wreg1), .i_wen0(i_wen0), .i_wen1(i_wen1),
    .i_wdata0(i_wdata0), .i_wdata1(i_wdata1), .o_rdata0(o_rdata0),
    .o_rdata1(o_rdata1), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wen(o_wen),
    .o_raddr(o_raddr), .i_rdata(i_rdata)
  );

  logic [1:0] ram [0:1023];
  logic       pre_we = 1'b0;
  logic [9:0] pre_addr = '0;
  logic [1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (o_wen) ram[o_waddr] <= o_wdata;
    i_rdata <= ram[o_raddr];
  end

  int n_cmp = 0;
  int n_err = 0;

  // Per-operation capture
  logic [31:0] rdA0, rdA1, rdB0, rdB1;
  logic        rd36;
  int          rdy_n;
  int          rdy_c [0:7];
  int          wl_n;
  int          wl_c [0:63];
  logic [9:0]  wl_a [0:63];
  logic [1:0]  wl_d [0:63];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] r, input logic [31:0] v);
    for (int k = 0; k < 16; k++) begin
      pre_we   = 1'b1;
      pre_addr = {r, 4'(k)};
      pre_data = v[2*k +: 2];
      tick();
    end
    pre_we = 1'b0;
  endtask

  // Offset 0 is the request cycle; a second read (rreg0=6, rreg1=5) is
  // requested at req2_at when non-negative, and reset pulses at rst_at.
  task automatic run_op(input logic rq, input logic wq,
                        input logic [5:0] r0, input logic [5:0] r1,
                        input logic [5:0] w0, input logic [5:0] w1,
                        input logic [31:0] wd0, input logic [31:0] wd1,
                        input logic we0, input logic we1,
                        input int rst_at, input int req2_at);
    rdA0 = '0; rdA1 = '0; rdB0 = '0; rdB1 = '0; rd36 = 1'b0;
    rdy_n = 0; wl_n = 0;
    for (int c = 0; c < 76; c++) begin
      i_rreq = 1'b0; i_wreq = 1'b0;
      if (c == 0) begin
        i_rreq = rq; i_wreq = wq;
        i_rreg0 = r0; i_rreg1 = r1; i_wreg0 = w0; i_wreg1 = w1;
      end else if (c == req2_at) begin
        i_rreq = 1'b1; i_rreg0 = 6'd6; i_rreg1 = 6'd5;
      end
      i_rst = (c == rst_at);
      if (c >= 4 && c <= 35) begin
        i_wdata0 = wd0[c-4]; i_wdata1 = wd1[c-4];
        i_wen0 = we0; i_wen1 = we1;
      end else begin
        i_wdata0 = 1'b0; i_wdata1 = 1'b0; i_wen0 = 1'b0; i_wen1 = 1'b0;
      end
      @(negedge clk);
      if (o_ready === 1'b1) begin
        if (rdy_n < 8) rdy_c[rdy_n] = c;
        rdy_n++;
      end
      if (o_wen === 1'b1 && wl_n < 64) begin
        wl_c[wl_n] = c; wl_a[wl_n] = o_waddr; wl_d[wl_n] = o_wdata;
        wl_n++;
      end
      if (c >= 4 && c <= 35) begin
        rdA0[c-4] = o_rdata0; rdA1[c-4] = o_rdata1;
      end
      if (c == 36) rd36 = o_rdata0 | o_rdata1;
      if (req2_at >= 0 && c >= req2_at + 4 && c <= req2_at + 35) begin
        rdB0[c-req2_at-4] = o_rdata0; rdB1[c-req2_at-4] = o_rdata1;
      end
      tick();
    end
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", o_ready); end
    n_cmp++; if (o_wen !== 1'b0) begin n_err++; $display("FAIL reset_wen got %b want 0", o_wen); end
    n_cmp++; if (o_rdata0 !== 1'b0 || o_rdata1 !== 1'b0) begin
      n_err++; $display("FAIL reset_rdata got %b%b want 00", o_rdata1, o_rdata0); end
    n_cmp++; if (dut.state !== dut.IDLE || dut.cnt !== 5'd0) begin
      n_err++; $display("FAIL reset_state got state=%0d cnt=%0d want 0/0", dut.state, dut.cnt); end
    tick();
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    preload(6'd5, 32'hDEADBEEF);
    preload(6'd6, 32'h12345678);
    run_op(1'b1, 1'b0, 6'd5, 6'd6, 6'd0, 6'd0, '0, '0, 1'b0, 1'b0, -1, -1);
    n_cmp++; if (rdy_n !== 1 || rdy_c[0] !== 3) begin
      n_err++; $display("FAIL read_ready got n=%0d at %0d want n=1 at 3", rdy_n, rdy_c[0]); end
    n_cmp++; if (rdA0 !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_rdata0 got %h want deadbeef", rdA0); end
    n_cmp++; if (rdA1 !== 32'h12345678) begin n_err++; $display("FAIL read_rdata1 got %h want 12345678", rdA1); end
    n_cmp++; if (rd36 !== 1'b0) begin n_err++; $display("FAIL read_after_run got %b want 0", rd36); end
    n_cmp++; if (wl_n !== 0) begin n_err++; $display("FAIL read_nowrite got %0d writes want 0", wl_n); end
  endtask

  task automatic test_read_x0();
    preload(6'd0, 32'hFFFFFFFF);
    run_op(1'b1, 1'b0, 6'd0, 6'd5, 6'd0, 6'd0, '0, '0, 1'b0, 1'b0, -1, -1);
    n_cmp++; if (rdA0 !== 32'h0) begin n_err++; $display("FAIL x0_rdata0 got %h want 00000000", rdA0); end
    n_cmp++; if (rdA1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL x0_rdata1 got %h want deadbeef", rdA1); end
  endtask

  task automatic test_write();
    logic [31:0] wd;
    wd = 32'hA5A5A5A5;
    run_op(1'b0, 1'b1, 6'd0, 6'd0, 6'd7, 6'd8, wd, '0, 1'b1, 1'b0, -1, -1);
    n_cmp++; if (wl_n !== 16) begin n_err++; $display("FAIL write_count got %0d want 16", wl_n); end
    for (int k = 0; k < 16 && k < wl_n; k++) begin
      n_cmp++;
      if (wl_c[k] !== 6 + 2*k || wl_a[k] !== {6'd7, 4'(k)} || wl_d[k] !== wd[2*k +: 2]) begin
        n_err++;
        $display("FAIL write_word%0d got c=%0d a=%h d=%b want c=%0d a=%h d=%b",
                 k, wl_c[k], wl_a[k], wl_d[k], 6 + 2*k, {6'd7, 4'(k)}, wd[2*k +: 2]);
      end
    end
    run_op(1'b0, 1'b1, 6'd0, 6'd0, 6'd0, 6'd8, wd, '0, 1'b1, 1'b0, -1, -1);
    n_cmp++; if (wl_n !== 0) begin n_err++; $display("FAIL write_x0 got %0d writes want 0", wl_n); end
  endtask

  task automatic test_concurrent();
    logic [31:0] wd0, wd1;
    wd0 = 32'h0F0F1234;
    wd1 = 32'hCAFEF00D;
    run_op(1'b1, 1'b1, 6'd5, 6'd6, 6'd9, 6'd32, wd0, wd1, 1'b1, 1'b1, -1, -1);
    n_cmp++; if (rdy_n !== 1 || rdy_c[0] !== 3) begin
      n_err++; $display("FAIL conc_ready got n=%0d at %0d want n=1 at 3", rdy_n, rdy_c[0]); end
    n_cmp++; if (rdA0 !== 32'hDEADBEEF || rdA1 !== 32'h12345678) begin
      n_err++; $display("FAIL conc_rdata got %h/%h want deadbeef/12345678", rdA0, rdA1); end
    n_cmp++; if (wl_n !== 32) begin n_err++; $display("FAIL conc_count got %0d want 32", wl_n); end
    for (int k = 0; k < 16 && 2*k+1 < wl_n; k++) begin
      n_cmp++;
      if (wl_c[2*k] !== 6 + 2*k || wl_a[2*k] !== {6'd9, 4'(k)} || wl_d[2*k] !== wd0[2*k +: 2] ||
          wl_c[2*k+1] !== 7 + 2*k || wl_a[2*k+1] !== {6'd32, 4'(k)} || wl_d[2*k+1] !== wd1[2*k +: 2]) begin
        n_err++;
        $display("FAIL conc_word%0d got p0 c=%0d a=%h d=%b p1 c=%0d a=%h d=%b",
                 k, wl_c[2*k], wl_a[2*k], wl_d[2*k], wl_c[2*k+1], wl_a[2*k+1], wl_d[2*k+1]);
      end
    end
  endtask

  task automatic test_busy();
    run_op(1'b1, 1'b0, 6'd5, 6'd6, 6'd0, 6'd0, '0, '0, 1'b0, 1'b0, -1, 13);
    n_cmp++; if (rdy_n !== 1) begin n_err++; $display("FAIL busy_ready got n=%0d want 1", rdy_n); end
    n_cmp++; if (rdA0 !== 32'hDEADBEEF || rdA1 !== 32'h12345678) begin
      n_err++; $display("FAIL busy_rdata got %h/%h want deadbeef/12345678", rdA0, rdA1); end
  endtask

  task automatic test_reset_mid();
    int late;
    run_op(1'b1, 1'b1, 6'd5, 6'd6, 6'd20, 6'd21, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 13, -1);
    late = 0;
    for (int i = 0; i < wl_n; i++) if (wl_c[i] >= 14) late++;
    n_cmp++; if (late !== 0) begin n_err++; $display("FAIL rstmid_wen got %0d late writes want 0", late); end
    n_cmp++; if (wl_n !== 8) begin n_err++; $display("FAIL rstmid_early got %0d writes want 8", wl_n); end
    n_cmp++; if (rdy_n !== 1) begin n_err++; $display("FAIL rstmid_ready got n=%0d want 1", rdy_n); end
    n_cmp++; if (rdA0 !== {22'h0, 10'h2EF}) begin n_err++; $display("FAIL rstmid_rdata got %h want 000002ef", rdA0); end
    n_cmp++; if (dut.state !== dut.IDLE) begin n_err++; $display("FAIL rstmid_state got %0d want 0", dut.state); end
  endtask

  task automatic test_back_to_back();
    run_op(1'b0, 1'b1, 6'd0, 6'd0, 6'd10, 6'd11, 32'h0, 32'h80000000, 1'b1, 1'b1, -1, 35);
    n_cmp++; if (wl_n !== 32 || wl_c[31] !== 37 || wl_a[31] !== {6'd11, 4'd15} || wl_d[31] !== 2'b10) begin
      n_err++; $display("FAIL b2b_drain got n=%0d c=%0d a=%h d=%b want 32/37/%h/10",
                        wl_n, wl_c[31], wl_a[31], wl_d[31], {6'd11, 4'd15}); end
    n_cmp++; if (rdy_n !== 2 || rdy_c[1] !== 38) begin
      n_err++; $display("FAIL b2b_ready got n=%0d at %0d want n=2 at 38", rdy_n, rdy_c[1]); end
    n_cmp++; if (rdB0 !== 32'h12345678 || rdB1 !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL b2b_rdata got %h/%h want 12345678/deadbeef", rdB0, rdB1); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_read_x0();
    test_write();
    test_concurrent();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
